// File: rtl/bus_arbiter_if.sv
// Requester handshake and external bus signals for bus_arbiter.
// The arbiter uses the slave modport; a requester/bus-side model uses master.
interface bus_arbiter_if;
    logic        req0_valid;
    logic        req0_wr;
    logic [19:0] req0_addr;
    logic [63:0] req0_wdata;
    logic [7:0]  req0_wtag;
    logic        req0_ready;
    logic        req0_done;

    logic        req1_valid;
    logic        req1_wr;
    logic [19:0] req1_addr;
    logic [63:0] req1_wdata;
    logic [7:0]  req1_wtag;
    logic        req1_ready;
    logic        req1_done;

    logic [63:0] rdata;
    logic [7:0]  rtag;

    logic [63:0] o_ad;
    logic [7:0]  o_tag;
    logic        o_astb;
    logic        o_rd;
    logic        o_wr;
    logic [63:0] i_data;
    logic [7:0]  i_tag;

    modport slave (
        input  req0_valid, req0_wr, req0_addr, req0_wdata, req0_wtag,
        input  req1_valid, req1_wr, req1_addr, req1_wdata, req1_wtag,
        input  i_data, i_tag,
        output req0_ready, req0_done, req1_ready, req1_done,
        output rdata, rtag,
        output o_ad, o_tag, o_astb, o_rd, o_wr
    );

    modport master (
        output req0_valid, req0_wr, req0_addr, req0_wdata, req0_wtag,
        output req1_valid, req1_wr, req1_addr, req1_wdata, req1_wtag,
        output i_data, i_tag,
        input  req0_ready, req0_done, req1_ready, req1_done,
        input  rdata, rtag,
        input  o_ad, o_tag, o_astb, o_rd, o_wr
    );
endinterface

// File: rtl/bus_arbiter.sv
// Two-requester arbiter driving a single address/data/done bus transaction at a time.
// Define ROUND_ROBIN_EN for alternating grants on contention; otherwise req0 has fixed priority.
module bus_arbiter #(
    parameter int WAIT_CYCLES = 2
) (
    input logic        clk,
    input logic        reset,
    bus_arbiter_if.slave bus
);

    localparam int WAIT_CLAMP = (WAIT_CYCLES < 1) ? 1 : ((WAIT_CYCLES > 15) ? 15 : WAIT_CYCLES);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CLAMP - 1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    state_t      state;
    logic [3:0]  count;
    logic        lat_id;
    logic        lat_wr;
    logic [19:0] lat_addr;
    logic [63:0] lat_wdata;
    logic [7:0]  lat_wtag;

    logic [63:0] rdata_q;
    logic [7:0]  rtag_q;
    logic        done0_q;
    logic        done1_q;
    logic        astb_q;
    logic        rd_q;
    logic        wr_q;
    logic [63:0] ad_q;
    logic [7:0]  tag_q;

    logic        any_valid;
    logic        grant_id;
    logic        grant_en;
    logic        sel_wr;
    logic [19:0] sel_addr;
    logic [63:0] sel_wdata;
    logic [7:0]  sel_wtag;

    assign any_valid = bus.req0_valid | bus.req1_valid;

`ifdef ROUND_ROBIN_EN
    logic last_grant;

    // On contention the requester that did not win last time goes next.
    assign grant_id = (bus.req0_valid && bus.req1_valid) ? ~last_grant : bus.req1_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (grant_en) begin
            last_grant <= grant_id;
        end
    end
`else
    assign grant_id = ~bus.req0_valid & bus.req1_valid;
`endif

    assign grant_en  = (state == IDLE) && any_valid && !reset;
    assign sel_wr    = grant_id ? bus.req1_wr    : bus.req0_wr;
    assign sel_addr  = grant_id ? bus.req1_addr  : bus.req0_addr;
    assign sel_wdata = grant_id ? bus.req1_wdata : bus.req0_wdata;
    assign sel_wtag  = grant_id ? bus.req1_wtag  : bus.req0_wtag;

    assign bus.req0_ready = grant_en & ~grant_id;
    assign bus.req1_ready = grant_en &  grant_id;
    assign bus.req0_done  = done0_q;
    assign bus.req1_done  = done1_q;
    assign bus.rdata      = rdata_q;
    assign bus.rtag       = rtag_q;
    assign bus.o_astb     = astb_q;
    assign bus.o_rd       = rd_q;
    assign bus.o_wr       = wr_q;
    assign bus.o_ad       = ad_q;
    assign bus.o_tag      = tag_q;

    // Bus outputs are computed for the state being entered, so they are registered and drop with reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            count     <= 4'd0;
            lat_id    <= 1'b0;
            lat_wr    <= 1'b0;
            lat_addr  <= 20'd0;
            lat_wdata <= 64'd0;
            lat_wtag  <= 8'd0;
            rdata_q   <= 64'd0;
            rtag_q    <= 8'd0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            astb_q    <= 1'b0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            ad_q      <= 64'd0;
            tag_q     <= 8'd0;
        end else begin
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            astb_q  <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            ad_q    <= 64'd0;
            tag_q   <= 8'd0;
            unique case (state)
                IDLE: begin
                    if (grant_en) begin
                        lat_id    <= grant_id;
                        lat_wr    <= sel_wr;
                        lat_addr  <= sel_addr;
                        lat_wdata <= sel_wdata;
                        lat_wtag  <= sel_wtag;
                        astb_q    <= 1'b1;
                        ad_q      <= {44'd0, sel_addr};
                        state     <= ADDR;
                    end
                end
                ADDR: begin
                    count <= WAIT_LOAD;
                    rd_q  <= ~lat_wr;
                    wr_q  <= lat_wr;
                    if (lat_wr) begin
                        ad_q  <= lat_wdata;
                        tag_q <= lat_wtag;
                    end
                    state <= DATA;
                end
                DATA: begin
                    if (count == 4'd0) begin
                        if (!lat_wr) begin
                            rdata_q <= bus.i_data;
                            rtag_q  <= bus.i_tag;
                        end
                        done0_q <= ~lat_id;
                        done1_q <= lat_id;
                        state   <= DONE;
                    end else begin
                        count <= count - 4'd1;
                        rd_q  <= ~lat_wr;
                        wr_q  <= lat_wr;
                        if (lat_wr) begin
                            ad_q  <= lat_wdata;
                            tag_q <= lat_wtag;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // lat_addr is only consumed at grant time through sel_addr; kept so the transaction record is complete.
    logic unused_addr;
    assign unused_addr = ^lat_addr;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: a transaction model predicts every output per cycle offset from grant.
// Builds with or without ROUND_ROBIN_EN; the arbitration model follows the same macro.
module tb_bus_arbiter;

    localparam int W        = 2;
    localparam int MAX_WAIT = 100;

`ifdef ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        int          id;
        bit          wr;
        logic [19:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wtag;
    } txn_t;

    typedef struct {
        int k;
        int rd_cycles;
        int done_off;
    } aux_exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   fixed_data = 1'b0;
    bit   model_last = 1'b1;

    txn_t     exp_q[$];
    aux_exp_t aux_q[$];

    bus_arbiter_if bus ();
    bus_arbiter_if bus_w0 ();
    bus_arbiter_if bus_w15 ();

    bus_arbiter #(.WAIT_CYCLES(W))  dut     (.clk(clk), .reset(reset), .bus(bus.slave));
    bus_arbiter #(.WAIT_CYCLES(0))  dut_w0  (.clk(clk), .reset(reset), .bus(bus_w0.slave));
    bus_arbiter #(.WAIT_CYCLES(15)) dut_w15 (.clk(clk), .reset(reset), .bus(bus_w15.slave));

    always #5 clk = ~clk;

    // Spec-level arbitration rule: fixed priority, or alternate against the last grant.
    function automatic int predict_winner(input bit v0, input bit v1);
        if (v0 && v1) return (RR && model_last == 1'b0) ? 1 : 0;
        return v0 ? 0 : 1;
    endfunction

    function automatic txn_t rand_txn(input int id);
        txn_t t;
        t.id    = id;
        t.wr    = 1'($urandom_range(0, 1));
        t.addr  = 20'($urandom);
        t.wdata = {$urandom, $urandom};
        t.wtag  = 8'($urandom);
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic timeout_fail(input string what);
        checks++;
        errors++;
        $display("[TB] FAIL %s_timeout: got no event within %0d cycles, required one", what, MAX_WAIT);
    endtask

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic drive_req(input int id, input bit v, input txn_t t);
        if (id == 0) begin
            bus.req0_valid = v;
            bus.req0_wr    = t.wr;
            bus.req0_addr  = t.addr;
            bus.req0_wdata = t.wdata;
            bus.req0_wtag  = t.wtag;
        end else begin
            bus.req1_valid = v;
            bus.req1_wr    = t.wr;
            bus.req1_addr  = t.addr;
            bus.req1_wdata = t.wdata;
            bus.req1_wtag  = t.wtag;
        end
    endtask

    task automatic apply_stimulus(input bit v0, input bit v1, input txn_t t0, input txn_t t1);
        int w;
        w = predict_winner(v0, v1);
        model_last = (w == 1);
        exp_q.push_back((w == 0) ? t0 : t1);
        drive_req(0, v0, t0);
        drive_req(1, v1, t1);
    endtask

    task automatic clear_reqs();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    task automatic wait_grant();
        for (int n = 0; n < MAX_WAIT; n++) begin
            #1;
            if (bus.req0_ready || bus.req1_ready) begin
                tick();
                return;
            end
            tick();
        end
        timeout_fail("grant");
    endtask

    task automatic wait_done();
        for (int n = 0; n < MAX_WAIT; n++) begin
            if (bus.req0_done || bus.req1_done) begin
                tick();
                return;
            end
            tick();
        end
        timeout_fail("done");
    endtask

    task automatic run_aux(input int k);
        aux_exp_t e;
        e.k         = k;
        e.rd_cycles = (k == 0) ? 1 : 15;
        e.done_off  = (k == 0) ? 3 : 17;
        aux_q.push_back(e);
        if (k == 0) bus_w0.req0_valid = 1'b1;
        else        bus_w15.req0_valid = 1'b1;
        tick();
        bus_w0.req0_valid  = 1'b0;
        bus_w15.req0_valid = 1'b0;
        for (int n = 0; n < MAX_WAIT; n++) begin
            if ((k == 0) ? bus_w0.req0_done : bus_w15.req0_done) begin
                tick();
                return;
            end
            tick();
        end
        timeout_fail("aux_done");
    endtask

    // External memory: fresh random read data every cycle unless a directed value is pinned.
    initial begin
        bus.i_data = 64'd0;
        bus.i_tag  = 8'd0;
        forever begin
            @(posedge clk);
            #1;
            if (fixed_data) begin
                bus.i_data = 64'h0123456789ABCDEF;
                bus.i_tag  = 8'h3A;
            end else begin
                bus.i_data = {$urandom, $urandom};
                bus.i_tag  = 8'($urandom);
            end
        end
    end

    always @(posedge reset) begin
        #1;
        checks++;
        if ({bus.o_astb, bus.o_rd, bus.o_wr, bus.o_ad, bus.o_tag, bus.req0_ready, bus.req1_ready,
             bus.req0_done, bus.req1_done, bus.rdata, bus.rtag} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got astb=%b rd=%b wr=%b ad=%h done=%b%b rdata=%h, required all 0",
                     bus.o_astb, bus.o_rd, bus.o_wr, bus.o_ad, bus.req0_done, bus.req1_done, bus.rdata);
        end
    end

    txn_t         cur;
    bit           active = 1'b0;
    int           offset = 0;
    logic [63:0]  model_rdata = 64'd0;
    logic [7:0]   model_rtag  = 8'd0;
    logic [63:0]  pend_rdata  = 64'd0;
    logic [7:0]   pend_rtag   = 8'd0;
    logic         e_r0, e_r1, e_d0, e_d1, e_astb, e_rd, e_wr;
    logic [63:0]  e_ad;
    logic [7:0]   e_tag;
    logic [150:0] act_vec, exp_vec;

    // Monitor: expected outputs come from the cycle offset since the grant of the queued transaction.
    always @(negedge clk) begin
        if (reset) begin
            active = 1'b0;
            exp_q.delete();
            model_rdata = 64'd0;
            model_rtag  = 8'd0;
        end else begin
            {e_r0, e_r1, e_d0, e_d1, e_astb, e_rd, e_wr} = '0;
            e_ad  = 64'd0;
            e_tag = 8'd0;
            if (!active && (bus.req0_ready || bus.req1_ready) && exp_q.size() > 0) begin
                cur    = exp_q[0];
                active = 1'b1;
                offset = 0;
            end else if (active) begin
                offset++;
            end
            if (active) begin
                if (offset == 0) begin
                    e_r0 = (cur.id == 0);
                    e_r1 = (cur.id == 1);
                end else if (offset == 1) begin
                    e_astb = 1'b1;
                    e_ad   = {44'd0, cur.addr};
                end else if (offset <= 1 + W) begin
                    e_rd = !cur.wr;
                    e_wr = cur.wr;
                    if (cur.wr) begin
                        e_ad  = cur.wdata;
                        e_tag = cur.wtag;
                    end else if (offset == 1 + W) begin
                        pend_rdata = bus.i_data;
                        pend_rtag  = bus.i_tag;
                    end
                end else begin
                    e_d0 = (cur.id == 0);
                    e_d1 = (cur.id == 1);
                    if (!cur.wr) begin
                        model_rdata = pend_rdata;
                        model_rtag  = pend_rtag;
                    end
                end
            end
            act_vec = {bus.req0_ready, bus.req1_ready, bus.req0_done, bus.req1_done, bus.o_astb,
                       bus.o_rd, bus.o_wr, bus.o_ad, bus.o_tag, bus.rdata, bus.rtag};
            exp_vec = {e_r0, e_r1, e_d0, e_d1, e_astb, e_rd, e_wr, e_ad, e_tag, model_rdata, model_rtag};
            checks++;
            if (act_vec !== exp_vec) begin
                errors++;
                $display("[TB] FAIL bus@%s: got %h expected %h",
                         active ? $sformatf("off%0d", offset) : "idle", act_vec, exp_vec);
            end
            checks++;
            if ((32'($countones({bus.o_astb, bus.o_rd, bus.o_wr})) > 1) ||
                (bus.req0_ready && bus.req1_ready) || (bus.req0_done && bus.req1_done)) begin
                errors++;
                $display("[TB] FAIL exclusive: got astb/rd/wr=%b ready=%b%b done=%b%b, required at most one each",
                         {bus.o_astb, bus.o_rd, bus.o_wr}, bus.req0_ready, bus.req1_ready,
                         bus.req0_done, bus.req1_done);
            end
            if (active && offset == 2 + W) begin
                void'(exp_q.pop_front());
                active = 1'b0;
            end
        end
    end

    logic aux_ready[2];
    logic aux_rd[2];
    logic aux_done[2];
    bit   aux_act[2];
    int   aux_off[2];
    int   aux_rd_cnt[2];
    aux_exp_t aux_e;

    assign aux_ready[0] = bus_w0.req0_ready;
    assign aux_ready[1] = bus_w15.req0_ready;
    assign aux_rd[0]    = bus_w0.o_rd;
    assign aux_rd[1]    = bus_w15.o_rd;
    assign aux_done[0]  = bus_w0.req0_done;
    assign aux_done[1]  = bus_w15.req0_done;

    initial begin
        aux_act[0] = 1'b0;
        aux_act[1] = 1'b0;
    end

    // Latency monitor for the WAIT_CYCLES=0 and =15 instances.
    always @(negedge clk) begin
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                if (!aux_act[k] && aux_ready[k]) begin
                    aux_act[k]    = 1'b1;
                    aux_off[k]    = 0;
                    aux_rd_cnt[k] = 0;
                end else if (aux_act[k]) begin
                    aux_off[k]++;
                    if (aux_rd[k]) aux_rd_cnt[k]++;
                    if (aux_done[k]) begin
                        aux_act[k] = 1'b0;
                        checks++;
                        if (aux_q.size() == 0) begin
                            errors++;
                            $display("[TB] FAIL aux%0d_unexpected_done: got done, required none", k);
                        end else begin
                            aux_e = aux_q.pop_front();
                            if (aux_e.k != k || aux_e.rd_cycles != aux_rd_cnt[k] || aux_e.done_off != aux_off[k]) begin
                                errors++;
                                $display("[TB] FAIL aux%0d_latency: got rd_cycles=%0d done_at=T+%0d expected rd_cycles=%0d done_at=T+%0d",
                                         k, aux_rd_cnt[k], aux_off[k], aux_e.rd_cycles, aux_e.done_off);
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no finish, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        txn_t t0, t1;
        int   mask, junk;

        t0 = rand_txn(0);
        drive_req(0, 1'b0, t0);
        drive_req(1, 1'b0, t0);
        {bus_w0.req0_valid, bus_w0.req0_wr, bus_w0.req1_valid, bus_w0.req1_wr} = '0;
        {bus_w15.req0_valid, bus_w15.req0_wr, bus_w15.req1_valid, bus_w15.req1_wr} = '0;
        bus_w0.req0_addr   = 20'h00ABC;  bus_w15.req0_addr  = 20'h00ABC;
        bus_w0.req1_addr   = 20'd0;      bus_w15.req1_addr  = 20'd0;
        bus_w0.req0_wdata  = 64'd0;      bus_w15.req0_wdata = 64'd0;
        bus_w0.req1_wdata  = 64'd0;      bus_w15.req1_wdata = 64'd0;
        bus_w0.req0_wtag   = 8'd0;       bus_w15.req0_wtag  = 8'd0;
        bus_w0.req1_wtag   = 8'd0;       bus_w15.req1_wtag  = 8'd0;
        bus_w0.i_data      = 64'h55;     bus_w15.i_data     = 64'h66;
        bus_w0.i_tag       = 8'h1;       bus_w15.i_tag      = 8'h2;

        #1 reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        model_last = 1'b1;

        $display("[TB] contention: both requesters valid for four transactions");
        t0 = rand_txn(0);
        t1 = rand_txn(1);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, 1'b1, t0, t1);
            wait_grant();
            wait_done();
        end
        clear_reqs();
        tick();

        $display("[TB] directed read by requester 0");
        fixed_data = 1'b1;
        t0 = rand_txn(0);
        t0.wr = 1'b0;
        t0.addr = 20'h00123;
        apply_stimulus(1'b1, 1'b0, t0, t0);
        wait_grant();
        clear_reqs();
        wait_done();
        fixed_data = 1'b0;
        check_output("read_rdata", bus.rdata, 64'h0123456789ABCDEF);
        check_output("read_rtag", {56'd0, bus.rtag}, 64'h3A);

        $display("[TB] directed write by requester 1");
        t1.id = 1;
        t1.wr = 1'b1;
        t1.addr = 20'hFFFFF;
        t1.wdata = 64'hDEADBEEFCAFEF00D;
        t1.wtag = 8'h55;
        apply_stimulus(1'b0, 1'b1, t1, t1);
        wait_grant();
        clear_reqs();
        wait_done();
        check_output("write_keeps_rdata", bus.rdata, 64'h0123456789ABCDEF);

        $display("[TB] reset during a read data phase");
        t0 = rand_txn(0);
        t0.wr = 1'b0;
        apply_stimulus(1'b1, 1'b0, t0, t0);
        wait_grant();
        clear_reqs();
        tick();
        #2 reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        model_last = 1'b1;
        check_output("reset_rdata", bus.rdata, 64'd0);
        t0 = rand_txn(0);
        t0.wr = 1'b0;
        apply_stimulus(1'b1, 1'b0, t0, t0);
        wait_grant();
        clear_reqs();
        wait_done();

        $display("[TB] randomized transactions with ignored requests while busy");
        for (int i = 0; i < 40; i++) begin
            mask = $urandom_range(1, 3);
            apply_stimulus(mask[0], mask[1], rand_txn(0), rand_txn(1));
            wait_grant();
            junk = $urandom_range(0, 3);
            drive_req(0, junk[0], rand_txn(0));
            drive_req(1, junk[1], rand_txn(1));
            tick();
            clear_reqs();
            wait_done();
        end

        $display("[TB] data-phase length at WAIT_CYCLES 0 and 15");
        run_aux(0);
        run_aux(1);
        tick();
        tick();

        checks++;
        if (exp_q.size() != 0 || aux_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL leftover: got %0d main and %0d aux pending, required 0", exp_q.size(), aux_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, data-phase length in clocks (legal 1..15; 0 treated as 1).
REQ-002 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports reqN_valid  input  1  requester N (N=0,1) transaction request.
REQ-005 SHALL have ports reqN_wr  input  1  requester N op: 1=write, 0=read.
REQ-006 SHALL have ports reqN_addr  input  20  requester N word address.
REQ-007 SHALL have ports reqN_wdata  input  64  and reqN_wtag  input  8  requester N write data and tag.
REQ-008 SHALL have ports reqN_ready  output  1  grant/accept strobe to requester N.
REQ-009 SHALL have ports reqN_done  output  1  completion pulse to requester N.
REQ-010 SHALL have ports rdata  output  64  and rtag  output  8  read data/tag shared by both requesters.
REQ-011 SHALL have ports o_ad  output  64, o_tag  output  8, o_astb  output  1, o_rd  output  1, o_wr  output  1  external bus.
REQ-012 SHALL have ports i_data  input  64  and i_tag  input  8  external read data/tag.

Function
REQ-013 SHALL implement FSM IDLE -> ADDR -> DATA -> DONE -> IDLE.
REQ-014 In IDLE with any reqN_valid, SHALL assert the winner's reqN_ready combinationally for that cycle, latch its wr/addr/wdata/wtag and id, and enter ADDR.
REQ-015 Requesters SHALL hold all request fields stable while valid and ready is low; valid dropped before ready cancels the request with no bus activity.
REQ-016 ADDR (1 cycle): o_astb=1, o_ad={44'b0,addr}, o_tag=0, o_rd=o_wr=0.
REQ-017 DATA (WAIT_CYCLES cycles, 4-bit down-counter): o_rd=!wr or o_wr=wr; on write o_ad=wdata, o_tag=wtag; on read o_ad=0.
REQ-018 Read SHALL capture i_data/i_tag into rdata/rtag on the last DATA cycle; rdata/rtag hold until the next read capture; writes leave them unchanged.
REQ-019 DONE (1 cycle): assert done of the latched requester only; all bus outputs 0.
REQ-020 Latency: grant at cycle T, astb T+1, data T+2..T+1+WAIT_CYCLES, done T+2+WAIT_CYCLES; next grant no earlier than T+3+WAIT_CYCLES.
REQ-021 reqN_valid changes outside IDLE SHALL be ignored; at most one transaction outstanding.
REQ-022 o_astb, o_rd, o_wr SHALL be mutually exclusive every cycle; at most one ready and one done asserted per cycle.
REQ-023 Arbitration with both valid SHALL follow REQ-027/REQ-028.

Reset
REQ-024 Reset SHALL immediately force IDLE, counter 0, last-grant pointer=1, rdata/rtag=0, all outputs 0.
REQ-025 Reset mid-transaction SHALL abort it: no done pulse, bus strobes drop asynchronously.
REQ-026 First rising edge after reset release SHALL evaluate requests normally.

Configuration
REQ-027 With ROUND_ROBIN_EN defined: simultaneous requests grant the requester not granted last; pointer updates on each grant.
REQ-028 Without ROUND_ROBIN_EN: req0 always wins simultaneous requests; pointer logic absent.

Verification
REQ-029 Read: req0 addr=20'h00123, WAIT_CYCLES=2, i_data=64'h0123456789ABCDEF, i_tag=8'h3A -> astb with o_ad=64'h123 at T+1, o_rd T+2..T+3, req0_done T+4, rdata/rtag = those values.
REQ-030 Write: req1 addr=20'hFFFFF, wdata=64'hDEADBEEFCAFEF00D, wtag=8'h55 -> o_ad=64'hFFFFF with astb, then o_wr with o_ad=wdata, o_tag=8'h55 two cycles, req1_done only.
REQ-031 Contention, ROUND_ROBIN_EN: both valid continuously for 4 transactions -> grants 0,1,0,1; without macro -> 0,0,0,0.
REQ-032 Reset asserted during DATA of a read -> o_rd=0 same cycle, no done, rdata=0; after release a new req0 completes normally.
REQ-033 WAIT_CYCLES=0 and 15 -> DATA lasts 1 and 15 cycles; done at T+3 and T+17.
REQ-034 Every cycle of all scenarios: checker asserts astb/rd/wr mutual exclusion and single ready/done.
